// File: rtl/iob2axil.sv
// Native request/response bus to AXI-Lite master bridge.
// Handles one transaction at a time; the request is captured on acceptance and replayed on AXI.
module iob2axil #(
    parameter int unsigned AXIL_ADDR_W = 32,
    parameter int unsigned AXIL_DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,

    input  logic                       valid,
    input  logic [AXIL_ADDR_W-1:0]     addr,
    input  logic [AXIL_DATA_W-1:0]     wdata,
    input  logic [AXIL_DATA_W/8-1:0]   wstrb,
    output logic [AXIL_DATA_W-1:0]     rdata,
    output logic                       ready,
    output logic                       error,

    output logic [AXIL_ADDR_W-1:0]     axil_awaddr,
    output logic [2:0]                 axil_awprot,
    output logic                       axil_awvalid,
    input  logic                       axil_awready,

    output logic [AXIL_DATA_W-1:0]     axil_wdata,
    output logic [AXIL_DATA_W/8-1:0]   axil_wstrb,
    output logic                       axil_wvalid,
    input  logic                       axil_wready,

    input  logic [1:0]                 axil_bresp,
    input  logic                       axil_bvalid,
    output logic                       axil_bready,

    output logic [AXIL_ADDR_W-1:0]     axil_araddr,
    output logic [2:0]                 axil_arprot,
    output logic                       axil_arvalid,
    input  logic                       axil_arready,

    input  logic [AXIL_DATA_W-1:0]     axil_rdata,
    input  logic [1:0]                 axil_rresp,
    input  logic                       axil_rvalid,
    output logic                       axil_rready
);

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StWresp,
        StRaddr,
        StRdata,
        StDone
    } state_e;

    state_e                     state_q;
    logic [AXIL_ADDR_W-1:0]     addr_q;
    logic [AXIL_DATA_W-1:0]     wdata_q;
    logic [AXIL_DATA_W/8-1:0]   wstrb_q;
    logic                       awvalid_q;
    logic                       wvalid_q;
    logic                       arvalid_q;
    logic [AXIL_DATA_W-1:0]     rdata_q;
    logic                       err_q;

    // A channel counts as done once its flag has dropped or it handshakes this cycle.
    logic aw_done;
    logic w_done;
    assign aw_done = ~awvalid_q | axil_awready;
    assign w_done  = ~wvalid_q | axil_wready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (valid) begin
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        wstrb_q <= wstrb;
                        if (wstrb != '0) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= StWrite;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= StRaddr;
                        end
                    end
                end
                StWrite: begin
                    if (awvalid_q && axil_awready) awvalid_q <= 1'b0;
                    if (wvalid_q && axil_wready) wvalid_q <= 1'b0;
                    if (aw_done && w_done) state_q <= StWresp;
                end
                StWresp: begin
                    if (axil_bvalid) begin
                        err_q   <= (axil_bresp != 2'b00);
                        state_q <= StDone;
                    end
                end
                StRaddr: begin
                    if (axil_arready) begin
                        arvalid_q <= 1'b0;
                        state_q   <= StRdata;
                    end
                end
                StRdata: begin
                    if (axil_rvalid) begin
                        rdata_q <= axil_rdata;
                        err_q   <= (axil_rresp != 2'b00);
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign ready        = (state_q == StDone);
    assign error        = ready & err_q;
    assign rdata        = rdata_q;

    assign axil_awaddr  = addr_q;
    assign axil_awprot  = 3'b000;
    assign axil_awvalid = awvalid_q;
    assign axil_wdata   = wdata_q;
    assign axil_wstrb   = wstrb_q;
    assign axil_wvalid  = wvalid_q;
    assign axil_bready  = (state_q == StWresp);
    assign axil_araddr  = addr_q;
    assign axil_arprot  = 3'b000;
    assign axil_arvalid = arvalid_q;
    assign axil_rready  = (state_q == StRdata);

endmodule

// File: doc/iob2axil.md
IOB2AXIL -- requirements
Module: iob2axil

Interface
REQ-001 SHALL have parameter AXIL_ADDR_W, default 32, AXI-Lite and native address width in bits.
REQ-002 SHALL have parameter AXIL_DATA_W, default 32, data width in bits (multiple of 8).
REQ-003 SHALL have one clock and an asynchronous, active-low reset, as the following two ports:
REQ-004 SHALL have port clk, input, 1, sole clock; all state changes on rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have native slave inputs valid 1, addr AXIL_ADDR_W, wdata AXIL_DATA_W, wstrb AXIL_DATA_W/8 (nonzero = write, zero = read).
REQ-007 SHALL have native slave outputs rdata AXIL_DATA_W, ready 1, error 1 (response was not OKAY).
REQ-008 SHALL have AXI-Lite master write address outputs: axil_awaddr AXIL_ADDR_W, axil_awprot 3, axil_awvalid 1; input: axil_awready 1.
REQ-009 SHALL have write data outputs: axil_wdata AXIL_DATA_W, axil_wstrb AXIL_DATA_W/8, axil_wvalid 1; input: axil_wready 1.
REQ-010 SHALL have write response inputs: axil_bresp 2, axil_bvalid 1; output: axil_bready 1.
REQ-011 SHALL have read address outputs: axil_araddr AXIL_ADDR_W, axil_arprot 3, axil_arvalid 1; input: axil_arready 1.
REQ-012 SHALL have read data inputs: axil_rdata AXIL_DATA_W, axil_rresp 2, axil_rvalid 1; output: axil_rready 1.

Function
REQ-013 SHALL implement FSM states IDLE, WRITE, WRESP, RADDR, RDATA, DONE; one transaction outstanding at a time.
REQ-014 In IDLE with valid=1, SHALL register addr, wdata, wstrb and go to WRITE if wstrb!=0, else RADDR.
REQ-015 In WRITE, SHALL drive axil_awvalid and axil_wvalid from registered flags set on IDLE exit; each flag clears independently on its own valid&ready handshake.
REQ-016 SHALL leave WRITE for WRESP on the cycle both AW and W handshakes have completed (same or different cycles, either order).
REQ-017 In WRESP, SHALL hold axil_bready=1; on axil_bvalid=1 capture error=(axil_bresp!=0) and go to DONE.
REQ-018 In RADDR, SHALL hold axil_arvalid=1 until axil_arready=1, then go to RDATA.
REQ-019 In RDATA, SHALL hold axil_rready=1; on axil_rvalid=1 register rdata=axil_rdata, error=(axil_rresp!=0), go to DONE.
REQ-020 In DONE, SHALL assert ready=1 for exactly one cycle, ignore valid, and return to IDLE.
REQ-021 rdata SHALL hold its last captured value until the next read completes; write transactions SHALL NOT modify it.
REQ-022 error SHALL be valid only while ready=1 and SHALL be 0 otherwise.
REQ-023 axil_awaddr/axil_araddr/axil_wdata/axil_wstrb SHALL come from registered request and be stable while their valid is high.
REQ-024 axil_awprot and axil_arprot SHALL be constant 3'b000.
REQ-025 axil_bready SHALL be 0 outside WRESP; axil_rready SHALL be 0 outside RDATA.
REQ-026 Minimum latency: valid sampled at edge N -> ready high in cycle N+3 when slave responds with zero wait (AW/W or AR at N+1, B or R at N+2).
REQ-027 A bvalid/rvalid arriving in a state not expecting it SHALL be ignored (no state change).
REQ-028 Input changes on addr/wdata/wstrb after IDLE capture SHALL NOT affect the transaction in flight.

Reset
REQ-029 While rst_n=0, SHALL force state IDLE and ready, error, rdata, all *valid and *ready outputs, and request registers to 0, asynchronously.
REQ-030 Reset asserted mid-transaction SHALL abandon it; after deassertion no ready pulse is emitted for the abandoned request.

Verification
REQ-031 Write, zero-wait slave: valid, addr=0x10, wdata=0xDEADBEEF, wstrb=0xF -> awaddr=0x10, wdata=0xDEADBEEF in cycle N+1, ready=1,error=0 in N+3 only.
REQ-032 Read, arready delayed 3 cycles, rdata=0x12345678 -> arvalid held 4 cycles stable, rdata=0x12345678 with ready one cycle.
REQ-033 Write, wready 2 cycles after awready -> awvalid drops after its handshake, wvalid holds until its own, single ready pulse.
REQ-034 Read with rresp=2'b10 -> ready=1, error=1 same cycle; next OKAY write -> error=0.
REQ-035 rst_n low during WRESP, then bvalid after release -> no ready, outputs 0, FSM IDLE; subsequent read completes normally.
REQ-036 Back-to-back: valid held high through DONE -> second request starts only from IDLE, exactly one ready per transaction.
